// File: rtl/ymux_rr.sv
// ----------------------------------------------------------------------------
// ymux_rr : registered N-channel multiplexer with valid/ready handshakes.
//
// Chooses one of CHANNELS producer lanes and moves its word into a single
// output register stage. Two selection modes are supported:
//   mode = 0 : manual, the external sel input names the channel.
//   mode = 1 : round-robin, a rotating pointer picks the first requesting
//              channel at or after the pointer, so every lane that keeps
//              requesting is served within CHANNELS transfers.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    CHANNELS*WIDTH packed lanes, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel request
//   in_ready   per-channel accept, combinational, one-hot or zero
//   mode       0 = manual select, 1 = round-robin
//   sel        manual channel select (values >= CHANNELS never grant)
//   out_data   registered data of the granted channel
//   out_chan   registered index of the channel that supplied out_data
//   out_valid  out_data holds a word
//   out_ready  downstream accept
// ----------------------------------------------------------------------------
module ymux_rr #(
    parameter int  WIDTH    = 2,
    parameter int  CHANNELS = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_chan_q,  out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    logic [SELW-1:0]       grant_idx;
    logic                  grant_valid;
    logic [WIDTH-1:0]      grant_data;
    logic                  load;

    // Requests rotated so that bit k corresponds to channel (ptr+k) mod N.
    logic [2*CHANNELS-1:0] rot_full;
    logic [CHANNELS-1:0]   rot_valid;
    logic [SELW:0]         rr_sum;

    assign rot_full  = {in_valid, in_valid} >> ptr_q;
    assign rot_valid = rot_full[CHANNELS-1:0];

    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        rr_sum      = '0;
        if (mode == 1'b0) begin
            // Only in-range sel values can match, so an out-of-range
            // select leaves grant_valid low.
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel == SELW'(i)) begin
                    grant_idx   = SELW'(i);
                    grant_valid = in_valid[i];
                end
            end
        end else begin
            // Scan from the far end so the lowest rotated offset wins.
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                if (rot_valid[k]) begin
                    rr_sum = {1'b0, ptr_q} + (SELW+1)'(k);
                    if (rr_sum >= (SELW+1)'(CHANNELS)) begin
                        rr_sum = rr_sum - (SELW+1)'(CHANNELS);
                    end
                    grant_idx   = rr_sum[SELW-1:0];
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // The output register can take a word when empty or draining this edge.
    assign load = (!out_valid_q || out_ready) && grant_valid;

    // in_ready is held low while reset is asserted, independent of clk.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign in_ready[gi] = rst_n & load & (grant_idx == SELW'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                ptr_d = (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            // Drain without refill: data and channel keep their last value.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule
